riscv_multicycle_ctrl: RTL and testbench
========================================

Name: riscv_multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core. It sequences one shared memory port, one ALU and the register file over 3-5 cycles per instruction.
- Covers lw, sw, R-type, I-type ALU, beq and jal.
- Sits beside the multicycle data path and drives all of its mux selects and write strobes.
- Takes op, func3, func7 and Zero from the data path.

Parameters:
- ILLEGAL_HALT, 1, unknown opcode in DECODE: 1 = enter HALT until reset; 0 = treat as NOP and return to FETCH.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- op  in  7  Instr[6:0] from instruction register
- func3  in  3  Instr[14:12]
- func7  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write strobe
- Halted  out  1  FSM is in HALT

Behaviour:
- Moore FSM. State register updates on posedge clk.
- reset = 0 at an edge: state <= FETCH, from any state, including mid-instruction. No partial instruction completes.
- While reset = 0:
  - PCWrite, MemWrite, IRWrite and RegWrite are forced to 0 combinationally.
  - Halted = 0.
  - Selects show FETCH values.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Unlisted outputs are 0 in each state. ALUOp is internal: 00 add, 01 sub, 10 funct.
- States, their outputs and next state:
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10, PCUpdate = 1 -> DECODE
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 -> lw/sw: MEMADR; R: EXECR; I-ALU: EXECI; jal: JAL; beq: BEQ; other: HALT (ILLEGAL_HALT = 1) or FETCH
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00 -> op[5] = 0: MEMREAD, else MEMWR
  - MEMREAD: ResultSrc = 00, AdrSrc = 1 -> MEMWB
  - MEMWB: ResultSrc = 01, RegWrite = 1 -> FETCH
  - MEMWR: ResultSrc = 00, AdrSrc = 1, MemWrite = 1 -> FETCH
  - EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10 -> ALUWB
  - EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10 -> ALUWB
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1 -> ALUWB
  - ALUWB: ResultSrc = 00, RegWrite = 1 -> FETCH
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1 -> FETCH
  - HALT: all strobes 0, Halted = 1, self-loop until reset.
- PCWrite = PCUpdate | (Branch & Zero). Combinational: Zero is sampled in the BEQ cycle itself.
- ImmSrc is combinational from op: lw/I-ALU 00, sw 01, beq 10, jal 11, else 00.
- ALUControl is combinational:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, by func3:
    - 000: sub (001) if op[5] & func7, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - other: 000.
- Cycles per instruction: lw 5, sw 4, R/I 4, jal 4, beq 3.
- No combinational path from op to any strobe except via the state register. PCWrite additionally depends on Zero.

Optional Feature:
- Macro MC_MEM_READY_EN. When defined:
  - Adds input MemReady (1 bit).
  - FETCH, MEMREAD and MEMWR hold their state and outputs while MemReady = 0.
  - In FETCH, IRWrite and PCWrite are asserted only in the cycle where MemReady = 1.
  - MemWrite is held asserted in MEMWR until MemReady = 1.
- When undefined: no MemReady port; memory is treated as always ready and timing is exactly as above.

Test Plan:
- Reset: hold reset = 0 for 2 cycles in mid-EXECR, release -> next state FETCH, IRWrite = 1, PCWrite = 1, all other strobes 0.
- lw (op 0000011): 5 cycles FETCH-DECODE-MEMADR-MEMREAD-MEMWB -> AdrSrc = 1 in MEMREAD; RegWrite = 1 with ResultSrc = 01 only in MEMWB; ImmSrc = 00.
- sw (0100011): 4 cycles -> MemWrite = 1 exactly one cycle, in MEMWR, with AdrSrc = 1; ImmSrc = 01; RegWrite never 1.
- R-type sub (op 0110011, func3 000, func7 1) -> ALUControl = 001 in EXECR. Same with func7 = 0 -> 000. I-ALU addi with func7 = 1 -> 000, because op[5] = 0.
- beq (1100011): Zero = 1 in BEQ -> PCWrite = 1 for one cycle. Zero = 0 -> PCWrite = 0. Both take 3 cycles; ImmSrc = 10.
- Illegal op 1111111 with ILLEGAL_HALT = 1 -> HALT, Halted = 1, all strobes 0 for 10+ cycles until reset = 0. With MC_MEM_READY_EN, MemReady = 0 for 3 cycles in FETCH -> IRWrite and PCWrite stay 0 until MemReady = 1.

Source files
------------

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R, I-ALU, beq, jal).
// Define MC_MEM_READY_EN to add a MemReady input that stalls memory states.
module riscv_multicycle_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7,
  input  logic       Zero,
`ifdef MC_MEM_READY_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       Halted
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    JAL,
    ALUWB,
    BEQ,
    HALT
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       halted;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  state_t state;
  state_t nxt;
  ctl_t   ctl;
  ctl_t   cur;
  logic   mem_ready;
  logic   pc_upd;

`ifdef MC_MEM_READY_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      MEMREAD: c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      MEMWR: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      ALUWB: c.reg_write = 1'b1;
      BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      FETCH: if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECR;
          OP_I:         nxt = EXECI;
          OP_JAL:       nxt = JAL;
          OP_BEQ:       nxt = BEQ;
          default:      nxt = ILLEGAL_HALT ? HALT : FETCH;
        endcase
      end
      MEMADR:  nxt = op[5] ? MEMWR : MEMREAD;
      MEMREAD: if (mem_ready) nxt = MEMWB;
      MEMWB:   nxt = FETCH;
      MEMWR:   if (mem_ready) nxt = FETCH;
      EXECR:   nxt = ALUWB;
      EXECI:   nxt = ALUWB;
      JAL:     nxt = ALUWB;
      ALUWB:   nxt = FETCH;
      BEQ:     nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  // Outputs are registered alongside the state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      ctl   <= ctl_of(FETCH);
    end else begin
      state <= nxt;
      ctl   <= ctl_of(nxt);
    end
  end

  always_comb begin
    cur = ctl;
    if (!reset) cur = ctl_of(FETCH);
  end

  // Fetch-time PC update waits for the memory; jal's update does not.
  assign pc_upd = cur.pc_update & (~cur.ir_write | mem_ready);

  assign PCWrite   = reset & (pc_upd | (cur.branch & Zero));
  assign IRWrite   = reset & cur.ir_write & mem_ready;
  assign MemWrite  = reset & cur.mem_write;
  assign RegWrite  = reset & cur.reg_write;
  assign Halted    = reset & cur.halted;
  assign AdrSrc    = cur.adr_src;
  assign ResultSrc = cur.result_src;
  assign ALUSrcA   = cur.alu_src_a;
  assign ALUSrcB   = cur.alu_src_b;

  always_comb begin
    ALUControl = 3'b000;
    case (cur.alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (func3)
          3'b000:  ALUControl = (op[5] & func7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: directed instruction sequences,
// per-cycle expected control vectors checked by an independent monitor.
module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] func3 = '0;
  logic       func7 = 1'b0;
  logic       Zero = 1'b0;
`ifdef MC_MEM_READY_EN
  logic       MemReady = 1'b1;
  logic       t_rdy = 1'b1;
`endif
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  riscv_multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .op(op),
    .func3(func3),
    .func7(func7),
    .Zero(Zero),
`ifdef MC_MEM_READY_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite),
    .AdrSrc(AdrSrc),
    .MemWrite(MemWrite),
    .IRWrite(IRWrite),
    .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc),
    .ALUControl(ALUControl),
    .RegWrite(RegWrite),
    .Halted(Halted)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IA  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef enum {
    S_RST, S_FETCH, S_FWAIT, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BEQ, S_HALT
  } st_t;

  typedef struct {
    st_t         st;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  logic [6:0] t_op = '0;
  logic [2:0] t_f3 = '0;
  logic       t_f7 = 1'b0;
  logic       t_zero = 1'b0;
  logic       t_rst = 1'b0;
  logic [2:0] t_alc = '0;

  logic [16:0] act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, ALUControl, RegWrite, Halted};

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      LW, IA:  return 2'b00;
      SW:      return 2'b01;
      BQ:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [16:0] pk(
    input logic pcw, input logic adr, input logic mw, input logic irw,
    input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
    input logic [1:0] imm, input logic [2:0] alc,
    input logic rw, input logic h);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, alc, rw, h};
  endfunction

  function automatic logic [16:0] exp_of(input st_t st, input logic [6:0] o,
                                         input logic [2:0] alc, input logic z);
    logic [1:0] i;
    i = imm_of(o);
    case (st)
      S_RST:     return pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, i, 3'b000, 0, 0);
      S_FETCH:   return pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, i, 3'b000, 0, 0);
      S_FWAIT:   return pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, i, 3'b000, 0, 0);
      S_DECODE:  return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, i, 3'b000, 0, 0);
      S_MEMADR:  return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, i, 3'b000, 0, 0);
      S_MEMREAD: return pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, i, 3'b000, 0, 0);
      S_MEMWB:   return pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, i, 3'b000, 1, 0);
      S_MEMWR:   return pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, i, 3'b000, 0, 0);
      S_EXECR:   return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, i, alc, 0, 0);
      S_EXECI:   return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, i, alc, 0, 0);
      S_JAL:     return pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, i, 3'b000, 0, 0);
      S_ALUWB:   return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, i, 3'b000, 1, 0);
      S_BEQ:     return pk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, i, 3'b001, 0, 0);
      S_HALT:    return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, i, 3'b000, 0, 1);
      default:   return '0;
    endcase
  endfunction

  task automatic step(input st_t st);
    @(posedge clk);
    #1;
    reset = t_rst;
    op    = t_op;
    func3 = t_f3;
    func7 = t_f7;
    Zero  = t_zero;
`ifdef MC_MEM_READY_EN
    MemReady = t_rdy;
`endif
    q.push_back('{st, exp_of(st, t_op, t_alc, t_zero)});
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alc);
    t_op  = o;
    t_f3  = f3;
    t_f7  = f7;
    t_alc = alc;
  endtask

  task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alc);
    set_instr(o, f3, f7, alc);
    step(S_FETCH);
    step(S_DECODE);
    step(o == RT ? S_EXECR : S_EXECI);
    step(S_ALUWB);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e.v)
        $display("FAIL %s: got %05h expected %05h", e.st.name(), act, e.v);
      else
        passes++;
    end
  end

  initial begin
    t_rst = 1'b0;
    step(S_RST);
    step(S_RST);
    t_rst = 1'b1;

    set_instr(LW, 3'b010, 1'b0, 3'b000);
    step(S_FETCH);
    step(S_DECODE);
    step(S_MEMADR);
    step(S_MEMREAD);
    step(S_MEMWB);

    set_instr(SW, 3'b010, 1'b0, 3'b000);
    step(S_FETCH);
    step(S_DECODE);
    step(S_MEMADR);
    step(S_MEMWR);

    alu_instr(RT, 3'b000, 1'b1, 3'b001);
    alu_instr(RT, 3'b000, 1'b0, 3'b000);
    alu_instr(IA, 3'b000, 1'b1, 3'b000);
    alu_instr(RT, 3'b010, 1'b0, 3'b101);
    alu_instr(RT, 3'b110, 1'b0, 3'b011);
    alu_instr(IA, 3'b111, 1'b0, 3'b010);

    set_instr(BQ, 3'b000, 1'b0, 3'b000);
    t_zero = 1'b1;
    step(S_FETCH);
    step(S_DECODE);
    step(S_BEQ);
    t_zero = 1'b0;
    step(S_FETCH);
    step(S_DECODE);
    step(S_BEQ);

    set_instr(JL, 3'b000, 1'b0, 3'b000);
    step(S_FETCH);
    step(S_DECODE);
    step(S_JAL);
    step(S_ALUWB);

    // Reset lands in EXECR; the instruction must not write back.
    set_instr(RT, 3'b000, 1'b0, 3'b000);
    step(S_FETCH);
    step(S_DECODE);
    t_rst = 1'b0;
    step(S_RST);
    step(S_RST);
    t_rst = 1'b1;
    step(S_FETCH);
    step(S_DECODE);
    step(S_EXECR);
    step(S_ALUWB);

    set_instr(BAD, 3'b000, 1'b0, 3'b000);
    step(S_FETCH);
    step(S_DECODE);
    repeat (12) step(S_HALT);
    t_rst = 1'b0;
    step(S_RST);
    t_rst = 1'b1;
    set_instr(LW, 3'b010, 1'b0, 3'b000);
    step(S_FETCH);
    step(S_DECODE);
    step(S_MEMADR);
    step(S_MEMREAD);
    step(S_MEMWB);

`ifdef MC_MEM_READY_EN
    set_instr(SW, 3'b010, 1'b0, 3'b000);
    t_rdy = 1'b0;
    repeat (3) step(S_FWAIT);
    t_rdy = 1'b1;
    step(S_FETCH);
    step(S_DECODE);
    step(S_MEMADR);
    t_rdy = 1'b0;
    repeat (2) step(S_MEMWR);
    t_rdy = 1'b1;
    step(S_MEMWR);
    set_instr(LW, 3'b010, 1'b0, 3'b000);
    step(S_FETCH);
    step(S_DECODE);
    step(S_MEMADR);
    t_rdy = 1'b0;
    repeat (2) step(S_MEMREAD);
    t_rdy = 1'b1;
    step(S_MEMREAD);
    step(S_MEMWB);
    step(S_FETCH);
`endif

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
